// File: rtl/ar_rx_label_fifo.sv
// Receive-side label-filtered FWFT word FIFO for an ARINC serial receiver.
// Accepted {label, data} words are queued; overflow losses are flagged and counted.
module ar_rx_label_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter bit LBL_RST    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce_wr,
  input  logic [7:0]            sr_adr,
  input  logic [22:0]           sr_dat,
  input  logic                  lbl_we,
  input  logic [7:0]            lbl_adr,
  input  logic                  lbl_en,
  input  logic                  rd,
  input  logic                  clr_ovf,
  output logic [7:0]            dout_adr,
  output logic [22:0]           dout_dat,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  ovf,
  output logic [7:0]            drop_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);

  logic [255:0]            lbl_tab;
  logic [30:0]             mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [DEPTH_LOG2:0]     level_nxt;
  logic                    accept, push, pop, drop;
  logic [30:0]             wr_word, head_nxt;

  always_comb begin
    wr_word    = {sr_adr, sr_dat};
    accept     = ce_wr & lbl_tab[sr_adr];
    pop        = rd & ~empty;
    // A full FIFO still takes a word when the host pops in the same cycle.
    push       = accept & (~full | rd);
    drop       = accept & full & ~rd;
    rd_ptr_nxt = pop ? rd_ptr + 1'b1 : rd_ptr;
    level_nxt  = level + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
    // The new head bypasses memory when it is the word being written this cycle.
    head_nxt   = (push && (wr_ptr == rd_ptr_nxt)) ? wr_word : mem[rd_ptr_nxt];
  end

  // NOTE: storage array has no reset; only pointers and flags define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_word;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // sees pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      lbl_tab  <= {256{LBL_RST}};
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      ovf      <= 1'b0;
      drop_cnt <= '0;
      dout_adr <= '0;
      dout_dat <= '0;
    end else begin
      if (lbl_we) lbl_tab[lbl_adr] <= lbl_en;
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_ptr_nxt;
      level  <= level_nxt;
      empty  <= (level_nxt == '0);
      full   <= (level_nxt == FULL_LVL);
      if (level_nxt != '0) {dout_adr, dout_dat} <= head_nxt;
      // A drop in the same cycle as a clear restarts the count at one.
      if (drop) begin
        ovf <= 1'b1;
        if (clr_ovf)                drop_cnt <= 8'd1;
        else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
      end else if (clr_ovf) begin
        ovf      <= 1'b0;
        drop_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ar_rx_label_fifo.sv
// Self-checking bench for ar_rx_label_fifo: directed scenarios plus random traffic
// compared every cycle against a queue-based model of the buffer.
module tb_ar_rx_label_fifo;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce_wr = 1'b0;
  logic [7:0]  sr_adr = '0;
  logic [22:0] sr_dat = '0;
  logic        lbl_we = 1'b0;
  logic [7:0]  lbl_adr = '0;
  logic        lbl_en = 1'b0;
  logic        rd = 1'b0;
  logic        clr_ovf = 1'b0;
  logic [7:0]  dout_adr;
  logic [22:0] dout_dat;
  logic        empty, full, ovf;
  logic [4:0]  level;
  logic [7:0]  drop_cnt;

  ar_rx_label_fifo dut (
    .clk(clk), .rst(rst), .ce_wr(ce_wr), .sr_adr(sr_adr), .sr_dat(sr_dat),
    .lbl_we(lbl_we), .lbl_adr(lbl_adr), .lbl_en(lbl_en), .rd(rd), .clr_ovf(clr_ovf),
    .dout_adr(dout_adr), .dout_dat(dout_dat), .empty(empty), .full(full),
    .level(level), .ovf(ovf), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: a queue of words, a label array, and loss statistics.
  logic [30:0] q[$];
  bit          lbl_m [256];
  bit          m_ovf;
  int          m_drops;
  logic [30:0] m_head;
  bit          model_on = 1'b0;

  always @(posedge clk) begin
    bit acc, was_full;
    if (rst) begin
      q.delete();
      foreach (lbl_m[i]) lbl_m[i] = 1'b1;
      m_ovf = 0; m_drops = 0; m_head = '0;
      model_on = 1'b1;
    end else if (model_on) begin
      acc      = ce_wr && lbl_m[sr_adr];
      was_full = (q.size() == DEPTH);
      if (rd && q.size() > 0) void'(q.pop_front());
      if (clr_ovf) begin m_ovf = 0; m_drops = 0; end
      if (acc) begin
        if (was_full && !rd) begin
          m_ovf = 1;
          if (m_drops < 255) m_drops++;
        end else q.push_back({sr_adr, sr_dat});
      end
      if (lbl_we) lbl_m[lbl_adr] = lbl_en;
      if (q.size() > 0) m_head = q[0];
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("flags", {16'h0, level, empty, full, ovf, drop_cnt},
            {16'h0, 5'(q.size()), q.size() == 0, q.size() == DEPTH, m_ovf, 8'(m_drops)});
      check("head", {1'b0, dout_adr, dout_dat}, {1'b0, m_head});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    ce_wr = 0; lbl_we = 0; rd = 0; clr_ovf = 0; rst = 0;
  endtask

  task automatic send(input logic [7:0] a, input logic [22:0] d);
    ce_wr = 1; sr_adr = a; sr_dat = d;
    tick();
  endtask

  task automatic set_lbl(input logic [7:0] a, input logic en);
    lbl_we = 1; lbl_adr = a; lbl_en = en;
    tick();
  endtask

  initial begin
    rst = 1;
    @(posedge clk); #2; rst = 1;
    tick();
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_level", 32'(level), 0);
    check("rst_dout", {dout_adr, dout_dat}, 0);

    // T1 single word
    send(8'h5A, 23'h12345);
    check("t1_empty", 32'(empty), 0);
    check("t1_level", 32'(level), 1);
    check("t1_adr", 32'(dout_adr), 32'h5A);
    check("t1_dat", 32'(dout_dat), 32'h12345);
    rd = 1; tick();
    check("t1_pop_empty", 32'(empty), 1);
    check("t1_pop_level", 32'(level), 0);
    check("t1_hold", 32'(dout_adr), 32'h5A);

    // T2 label filter, plus same-cycle table write uses the old bit
    set_lbl(8'h30, 1'b0);
    send(8'h30, 23'h1); send(8'h31, 23'h2); send(8'h30, 23'h3);
    check("t2_level", 32'(level), 1);
    check("t2_adr", 32'(dout_adr), 32'h31);
    check("t2_drop", 32'(drop_cnt), 0);
    lbl_we = 1; lbl_adr = 8'h31; lbl_en = 0;
    send(8'h31, 23'h4);
    check("t2_oldbit", 32'(level), 2);
    send(8'h31, 23'h5);
    check("t2_newbit", 32'(level), 2);
    rd = 1; tick(); rd = 1; tick();

    // T3 fill and overflow
    for (int i = 1; i <= 16; i++) send(8'(i), 23'(i + 100));
    check("t3_full", 32'(full), 1);
    check("t3_level", 32'(level), 16);
    for (int i = 0; i < 3; i++) send(8'hEE, 23'h7);
    check("t3_ovf", 32'(ovf), 1);
    check("t3_drop", 32'(drop_cnt), 3);
    check("t3_head", 32'(dout_adr), 1);
    clr_ovf = 1; tick();
    check("t3_clr", {ovf, drop_cnt}, 0);

    // T4 push+pop at full; then rd while empty
    ce_wr = 1; sr_adr = 8'hAA; sr_dat = 23'h777; rd = 1; tick();
    check("t4_level", 32'(level), 16);
    check("t4_ovf", 32'(ovf), 0);
    for (int i = 2; i <= 17; i++) begin
      check("t4_drain", 32'(dout_adr), (i == 17) ? 32'hAA : 32'(i));
      rd = 1; tick();
    end
    rd = 1; tick();
    check("t4_empty_rd", {level, empty, full}, {5'd0, 1'b1, 1'b0});

    // T5 saturation and clear-vs-drop
    for (int i = 0; i < 16; i++) send(8'(i), 23'(i));
    for (int i = 0; i < 300; i++) send(8'h01, 23'(i));
    check("t5_sat", 32'(drop_cnt), 255);
    clr_ovf = 1; send(8'h02, 23'h9);
    check("t5_clr_drop", {ovf, drop_cnt}, {1'b1, 8'd1});

    // T6 reset mid-operation
    for (int i = 0; i < 9; i++) begin rd = 1; tick(); end
    check("t6_level7", 32'(level), 7);
    set_lbl(8'h40, 1'b0);
    rst = 1; tick();
    check("t6_rst", {level, empty, ovf, drop_cnt}, {5'd0, 1'b1, 1'b0, 8'd0});
    send(8'h40, 23'h55);
    check("t6_accept", {level, dout_adr}, {5'd1, 8'h40});
    send(8'h30, 23'h56);
    check("t6_accept30", 32'(level), 2);

    // Random traffic against the model
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 500; i++) begin
        ce_wr   = ($urandom_range(99) < 60);
        sr_adr  = ($urandom_range(3) == 0) ? 8'($urandom) : 8'($urandom_range(7));
        sr_dat  = 23'($urandom);
        lbl_we  = ($urandom_range(99) < 5);
        lbl_adr = 8'($urandom_range(7));
        lbl_en  = ($urandom_range(99) < 70);
        rd      = ($urandom_range(99) < ((ph % 2 == 0) ? 25 : 75));
        clr_ovf = ($urandom_range(99) < 3);
        rst     = ($urandom_range(999) < 3);
        tick();
      end
    end

    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
